// File: rtl/product_accumulator_if.sv
// Valid/ready stream bundle between the product source, the accumulator and the result consumer.
// slave = accumulator side, master = testbench / upstream+downstream side.
interface product_accumulator_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [23:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums groups of 24-bit unsigned products delimited by in_last into one registered result.
// S_IDLE: no group open (acc/cnt/ovf zero) | S_ACCUM: partial group held in r_acc/r_cnt/r_ovf.
module product_accumulator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic [ACC_W-1:0] w_acc_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_ovf_base;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_cnt_full;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // A fresh group starts from zero regardless of what the partial registers hold.
  assign w_acc_base = (r_state == S_ACCUM) ? r_acc : '0;
  assign w_cnt_base = (r_state == S_ACCUM) ? r_cnt : '0;
  assign w_ovf_base = (r_state == S_ACCUM) && r_ovf;

  assign w_sum_ext  = {1'b0, w_acc_base} + {{(ACC_W-23){1'b0}}, bus.in_data};
  assign w_cnt_full = &w_cnt_base;
  assign w_cnt_next = w_cnt_full ? w_cnt_base : w_cnt_base + CNT_W'(1);
  assign w_ovf_next = w_ovf_base || w_sum_ext[ACC_W] || w_cnt_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept && bus.in_last) begin
      // A completing group overwrites the output even when the old result leaves this cycle.
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum_ext[ACC_W-1:0];
      r_out_count <= w_cnt_next;
      r_out_ovf   <= w_ovf_next;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_state     <= S_IDLE;
    end else begin
      if (w_accept) begin
        r_acc   <= w_sum_ext[ACC_W-1:0];
        r_cnt   <= w_cnt_next;
        r_ovf   <= w_ovf_next;
        r_state <= S_ACCUM;
      end
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

endmodule
